tt800_ctl: RTL and testbench
============================

TT800_CTL -- requirements
Module: tt800_ctl

Interface
REQ-001 Parameter WARMUP, default 64: number of discarded generator steps after seeding; legal range 1..1023.
REQ-002 Port clk, input, 1: sole clock, rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port seed_req, input, 1: single-cycle pulse that starts (re)seeding with seed.
REQ-005 Port seed, input, 32: seed value, sampled in the cycle seed_req is high.
REQ-006 Port seeded, output, 1: high while in RUN (generator seeded and warmed up).
REQ-007 Port req0 and port req1, input, 1 each: word requests, level-sensitive.
REQ-008 Port gnt0 and port gnt1, output, 1 each: single-cycle grant; rnd_data is valid in the same cycle.
REQ-009 Port rnd_data, output, 32: granted random word, registered.
REQ-010 Ports gen_en (output, 1), gen_init (output, 1) and gen_initv (output, 32): drive the external TT800 generator's en, init and initv inputs; all registered.
REQ-011 Port gen_y, input, 32: registered tempered output of the TT800 generator.

Function
REQ-012 The state machine SHALL have four states: IDLE (unseeded), SEED, WARM and RUN.
REQ-013 A seed_req sampled in any state SHALL enter SEED, clear seeded, and load the seed counter with 0 and v0 = seed.
REQ-014 SEED SHALL hold gen_en=1 and gen_init=1 for exactly 25 cycles, with gen_initv = v0..v24, where v(k+1) = (v(k)*69069 + 1) mod 2^32.
REQ-015 WARM SHALL follow SEED immediately, holding gen_en=1 and gen_init=0 for exactly WARMUP cycles.
REQ-016 RUN SHALL follow: gen_en=0, seeded=1 and avail=1; seeded rises 25+WARMUP+1 cycles after the seed_req edge.
REQ-017 In RUN, at an edge where avail=1 and any req is high, the controller SHALL:
  - register gnt for the winning port;
  - register rnd_data <= gen_y;
  - register gen_en <= 1 for one cycle;
  - clear avail.
REQ-018 At the edge where gen_en=1 in RUN, avail SHALL be set to 1; the maximum grant rate is one word per 2 cycles.
REQ-019 Arbitration SHALL be round-robin: when both ports request, the port not granted last wins; a single requester wins immediately.
REQ-020 A requester holding req high across consecutive grants SHALL receive a distinct word each time; no word is delivered twice.
REQ-021 gnt0 and gnt1 SHALL never be high together, and SHALL be 0 outside RUN; requests outside RUN are held off, not dropped.
REQ-022 A seed_req during SEED or WARM SHALL restart SEED from the new seed.
REQ-023 A seed_req in the same cycle as a grant decision SHALL take priority: no grant is issued.
REQ-024 The seed counter SHALL be 5 bits wide; the warm-up counter SHALL be 10 bits wide; neither counter wraps.

Reset
REQ-025 On rst, state SHALL become IDLE.
REQ-026 On rst, all outputs SHALL be 0: seeded, gnt0, gnt1, rnd_data, gen_en, gen_init, gen_initv.
REQ-027 On rst, avail SHALL be 0 and the round-robin pointer SHALL be set so port 0 wins the first tie.
REQ-028 The generator has no reset; seeded SHALL stay 0 until a full seed sequence completes after reset.

Structure
REQ-029 The state encoding, constant 25 (state length) and constant 69069 (LCG multiplier) SHALL live in a shared package tt800_pkg.
REQ-030 One sub-module rr_arb2 (2-way round-robin arbiter) is natural; the generator itself SHALL be instantiated outside this block.

Verification
REQ-031 Seed sequence: seed_req with seed=1 -> gen_initv reads 1, 69070, 475628535 in the first three SEED cycles; gen_init is high exactly 25 cycles.
REQ-032 Warm-up timing: WARMUP=64 -> exactly 64 gen_en cycles with gen_init=0, then seeded=1 at 90 cycles after the seed_req edge.
REQ-033 Golden output: with the TT800 model attached, req0 held high for 10 words -> one gnt0 every 2 cycles, rnd_data matches the golden software TT800 output sequence after 64 discards.
REQ-034 Contention: req0 and req1 both held high -> grants alternate 0,1,0,1..., with no simultaneous grants and no duplicate words.
REQ-035 Abort mid-operation: seed_req during RUN while both ports request -> grants stop the next cycle, seeded=0, and the new seed sequence restarts from v0.
REQ-036 Mid-sequence reset: rst asserted mid-SEED -> all outputs 0 asynchronously; no grants occur until a new seed_req completes seeding.

Source files
------------

// File: rtl/tt800_pkg.sv
// tt800_pkg: shared definitions for the TT800 seeding/arbitration controller.
//   state_t   : controller state encoding
//   TT_N      : TT800 state length in words (words loaded during SEED)
//   LCG_MUL   : multiplier of the LCG that expands the 32-bit seed
//   lcg_next  : one LCG step, v*69069 + 1 mod 2^32
package tt800_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_WARM = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam int unsigned TT_N      = 25;
    localparam logic [31:0] LCG_MUL   = 32'd69069;
    localparam logic [4:0]  SEED_LAST = 5'(TT_N - 1);

    function automatic logic [31:0] lcg_next(input logic [31:0] v);
        return v * LCG_MUL + 32'd1;
    endfunction

endpackage

// File: rtl/tt800_ctl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_req0, i_req1 : request levels
//   i_adv          : the current winner is actually granted this cycle
//   o_win0, o_win1 : combinational winner (one-hot or zero)
// On a tie the port not granted last wins; after reset port 0 wins the first tie.
module rr_arb2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_adv,
    output logic o_win0,
    output logic o_win1
);

    logic r_last;   // 1: port 1 was granted last
    logic w_win1;

    assign w_win1 = i_req1 & (~i_req0 | ~r_last);
    assign o_win1 = w_win1;
    assign o_win0 = i_req0 & ~w_win1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (i_adv && (i_req0 || i_req1)) begin
            r_last <= w_win1;
        end
    end

endmodule

// File: rtl/tt800_ctl.sv
// tt800_ctl: seeds an external TT800 generator, warms it up and then hands
// out its words to two requesters with round-robin arbitration.
//   clk, rst         : clock, asynchronous active-high reset
//   seed_req, seed   : start (re)seeding with seed
//   seeded           : generator seeded and warmed up (RUN)
//   req0/1, gnt0/1   : word requests (level) and single-cycle grants
//   rnd_data         : granted word, valid with gnt0/gnt1
//   gen_en/init/initv: control of the external generator
//   gen_y            : registered tempered output of the generator
//
// state | meaning
// IDLE  | not seeded since reset
// SEED  | loading 25 LCG-expanded state words into the generator
// WARM  | stepping the generator WARMUP times, outputs discarded
// RUN   | serving requests; one word per grant, then one step
module tt800_ctl
    import tt800_pkg::*;
#(
    parameter int WARMUP = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_req,
    input  logic [31:0] seed,
    output logic        seeded,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] rnd_data,
    output logic        gen_en,
    output logic        gen_init,
    output logic [31:0] gen_initv,
    input  logic [31:0] gen_y
);

    localparam logic [9:0] WARM_LOAD = 10'(WARMUP - 1);

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_scnt, w_scnt_nxt;
    logic [9:0]  r_wcnt, w_wcnt_nxt;
    logic        r_avail, w_avail_nxt;
    logic        r_seeded, w_seeded_nxt;
    logic        r_gnt0, r_gnt1;
    logic [31:0] r_rnd, w_rnd_nxt;
    logic        r_gen_en, w_gen_en_nxt;
    logic        r_gen_init, w_gen_init_nxt;
    logic [31:0] r_initv, w_initv_nxt;
    logic        w_take;
    logic        w_win0, w_win1;

    rr_arb2 u_arb (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_req0 (req0),
        .i_req1 (req1),
        .i_adv  (w_take),
        .o_win0 (w_win0),
        .o_win1 (w_win1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_scnt     <= 5'd0;
            r_wcnt     <= 10'd0;
            r_avail    <= 1'b0;
            r_seeded   <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rnd      <= 32'd0;
            r_gen_en   <= 1'b0;
            r_gen_init <= 1'b0;
            r_initv    <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_scnt     <= w_scnt_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_avail    <= w_avail_nxt;
            r_seeded   <= w_seeded_nxt;
            r_gnt0     <= w_take & w_win0;
            r_gnt1     <= w_take & w_win1;
            r_rnd      <= w_rnd_nxt;
            r_gen_en   <= w_gen_en_nxt;
            r_gen_init <= w_gen_init_nxt;
            r_initv    <= w_initv_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_scnt_nxt     = r_scnt;
        w_wcnt_nxt     = r_wcnt;
        w_avail_nxt    = r_avail;
        w_seeded_nxt   = 1'b0;
        w_rnd_nxt      = r_rnd;
        w_gen_en_nxt   = 1'b0;
        w_gen_init_nxt = 1'b0;
        w_initv_nxt    = r_initv;
        w_take         = 1'b0;

        // A seed request overrides everything, including a pending grant.
        if (seed_req) begin
            w_state_nxt    = ST_SEED;
            w_scnt_nxt     = 5'd0;
            w_initv_nxt    = seed;
            w_gen_en_nxt   = 1'b1;
            w_gen_init_nxt = 1'b1;
            w_avail_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_SEED: begin
                    w_gen_en_nxt = 1'b1;
                    if (r_scnt == SEED_LAST) begin
                        w_state_nxt = ST_WARM;
                        w_wcnt_nxt  = WARM_LOAD;
                    end else begin
                        w_gen_init_nxt = 1'b1;
                        w_scnt_nxt     = r_scnt + 5'd1;
                        w_initv_nxt    = lcg_next(r_initv);
                    end
                end
                ST_WARM: begin
                    if (r_wcnt == 10'd0) begin
                        w_state_nxt  = ST_RUN;
                        w_seeded_nxt = 1'b1;
                        w_avail_nxt  = 1'b1;
                    end else begin
                        w_gen_en_nxt = 1'b1;
                        w_wcnt_nxt   = r_wcnt - 10'd1;
                    end
                end
                ST_RUN: begin
                    w_seeded_nxt = 1'b1;
                    // The step issued after a grant refreshes gen_y; only
                    // then is a new word available.
                    if (r_gen_en) begin
                        w_avail_nxt = 1'b1;
                    end else if (r_avail && (req0 || req1)) begin
                        w_take       = 1'b1;
                        w_rnd_nxt    = gen_y;
                        w_gen_en_nxt = 1'b1;
                        w_avail_nxt  = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign seeded    = r_seeded;
    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rnd_data  = r_rnd;
    assign gen_en    = r_gen_en;
    assign gen_init  = r_gen_init;
    assign gen_initv = r_initv;

endmodule

// File: tb/tb_tt800_ctl.sv
module tb_tt800_ctl;

    localparam int W  = 64;
    localparam int SL = 25;
    localparam logic [31:0] MAG = 32'h8ebfd028;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_req = 1'b0;
    logic [31:0] seed = 32'd0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        seeded, gnt0, gnt1, gen_en, gen_init;
    logic [31:0] rnd_data, gen_initv;
    logic [31:0] gen_y = 32'd0;

    always #5 clk = ~clk;

    tt800_ctl #(.WARMUP(W)) dut (
        .clk(clk), .rst(rst), .seed_req(seed_req), .seed(seed),
        .seeded(seeded), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .rnd_data(rnd_data), .gen_en(gen_en), .gen_init(gen_init),
        .gen_initv(gen_initv), .gen_y(gen_y)
    );

    function automatic logic [31:0] temper(input logic [31:0] t);
        logic [31:0] y;
        y = t;
        y = y ^ ((y << 7) & 32'h2b5b2500);
        y = y ^ ((y << 15) & 32'hdb8b0000);
        y = y ^ (y >> 16);
        return y;
    endfunction

    function automatic logic [31:0] lcg(input logic [31:0] v);
        return v * 32'd69069 + 32'd1;
    endfunction

    // Attached generator: init shifts words in, each step twists one word;
    // gen_y always presents the word the next step would produce.
    logic [31:0] gx [0:24];
    int gk = 0;
    initial for (int i = 0; i < 25; i++) gx[i] = 32'd0;
    always @(posedge clk) begin
        logic [31:0] tw;
        if (gen_en) begin
            if (gen_init) begin
                for (int i = 0; i < 24; i++) gx[i] = gx[i+1];
                gx[24] = gen_initv;
                gk = 0;
            end else begin
                gx[gk] = gx[(gk+7)%25] ^ (gx[gk] >> 1) ^ (gx[gk][0] ? MAG : 32'd0);
                gk = (gk + 1) % 25;
            end
        end
        tw = gx[(gk+7)%25] ^ (gx[gk] >> 1) ^ (gx[gk][0] ? MAG : 32'd0);
        gen_y <= temper(tw);
    end

    // Golden software sequence for one seed: out[0..] of a fresh TT800.
    logic [31:0] gold [0:255];
    task automatic compute_gold(input logic [31:0] s);
        logic [31:0] x [0:24];
        int k;
        x[0] = s;
        for (int i = 1; i < 25; i++) x[i] = lcg(x[i-1]);
        k = 0;
        for (int n = 0; n < 256; n++) begin
            x[k] = x[(k+7)%25] ^ (x[k] >> 1) ^ (x[k][0] ? MAG : 32'd0);
            gold[n] = temper(x[k]);
            k = (k + 1) % 25;
        end
    endtask

    int n_err = 0, n_chk = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural model: m_sc = cycles since the seed was accepted (-1 = none).
    int          m_sc = -1;
    logic [31:0] m_v = 32'd0;
    int          m_last = 1;
    bit          m_g0 = 0, m_g1 = 0, m_gprev = 0;
    int          widx = 0, words = 0;

    task automatic model_edge();
        bit in_run;
        in_run = (m_sc >= SL + W);
        m_g0 = 0; m_g1 = 0;
        if (seed_req) begin
            m_sc = 0; m_v = seed; compute_gold(seed); widx = 0;
        end else begin
            if (in_run && !m_gprev && (req0 || req1)) begin
                if (req0 && req1) begin
                    if (m_last == 1) m_g0 = 1; else m_g1 = 1;
                end else if (req0) m_g0 = 1;
                else m_g1 = 1;
                m_last = m_g1 ? 1 : 0;
            end
            if (m_sc >= 0 && m_sc < SL + W) begin
                m_sc++;
                if (m_sc < SL) m_v = lcg(m_v);
            end
        end
        m_gprev = m_g0 | m_g1;
    endtask

    task automatic check_cycle();
        bit e_seeded, e_init, e_en;
        e_seeded = (m_sc >= SL + W);
        e_init   = (m_sc >= 0 && m_sc < SL);
        e_en     = (m_sc >= 0 && m_sc < SL + W) || m_gprev;
        chk("seeded", {31'd0, seeded}, {31'd0, e_seeded});
        chk("gen_init", {31'd0, gen_init}, {31'd0, e_init});
        chk("gen_en", {31'd0, gen_en}, {31'd0, e_en});
        chk("gnt0", {31'd0, gnt0}, {31'd0, m_g0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, m_g1});
        if (e_init) chk("gen_initv", gen_initv, m_v);
        if (m_gprev && widx < 192) begin
            chk("rnd_data", rnd_data, gold[64 + widx]);
            widx++; words++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_seeded"}, {31'd0, seeded}, 32'd0);
        chk({tag, "_gnt0"}, {31'd0, gnt0}, 32'd0);
        chk({tag, "_gnt1"}, {31'd0, gnt1}, 32'd0);
        chk({tag, "_rnd"}, rnd_data, 32'd0);
        chk({tag, "_en"}, {31'd0, gen_en}, 32'd0);
        chk({tag, "_init"}, {31'd0, gen_init}, 32'd0);
        chk({tag, "_initv"}, gen_initv, 32'd0);
    endtask

    task automatic model_reset();
        m_sc = -1; m_last = 1; m_gprev = 0; m_g0 = 0; m_g1 = 0;
    endtask

    task automatic seed_and_wait(input logic [31:0] s, input string tag);
        int n;
        seed = s; seed_req = 1'b1;
        cyc();
        seed_req = 1'b0;
        n = 1;
        while (!seeded && n < 300) begin cyc(); n++; end
        chk({tag, "_seed_done"}, {31'd0, seeded}, 32'd1);
    endtask

    task automatic run_words(input int nw, input string tag);
        int n;
        words = 0; n = 0;
        while (words < nw && n < 4 * nw + 10) begin cyc(); n++; end
        chk({tag, "_words"}, words, nw);
    endtask

    logic [31:0] v3 [0:2];
    initial begin
        int n, n_init, n_warm;
        v3[0] = 32'd1; v3[1] = 32'd69070; v3[2] = 32'd475628535;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Requests before seeding are held off.
        for (int i = 0; i < 6; i++) begin
            req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
            cyc();
        end

        // Seed 1: LCG words, 25 init cycles, 64 warm cycles, seeded at 90.
        req0 = 1'b1; req1 = 1'b0;
        seed = 32'd1; seed_req = 1'b1;
        n = 0; n_init = 0; n_warm = 0;
        while (!seeded && n < 200) begin
            cyc();
            seed_req = 1'b0;
            n++;
            if (n <= 3) chk("seed1_initv", gen_initv, v3[n-1]);
            if (gen_init) n_init++;
            else if (gen_en) n_warm++;
        end
        chk("seeded_latency", n, 26 + W);
        chk("init_cycles", n_init, SL);
        chk("warm_cycles", n_warm, W);

        // Golden: req0 alone for 10 words.
        run_words(10, "golden");

        // Contention: both held, alternating grants.
        req1 = 1'b1;
        run_words(10, "contend");

        // Random request levels.
        for (int i = 0; i < 120; i++) begin
            req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
            cyc();
        end

        // Abort in RUN with both requesting.
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        seed = $urandom; seed_req = 1'b1;
        cyc();
        seed_req = 1'b0;
        chk("abort_seeded", {31'd0, seeded}, 32'd0);
        chk("abort_initv", gen_initv, seed);

        // Restart during WARM, then during SEED.
        for (int i = 0; i < 40; i++) cyc();
        seed = $urandom; seed_req = 1'b1; cyc(); seed_req = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        seed_and_wait($urandom, "reseed");
        for (int i = 0; i < 60; i++) begin
            req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
            cyc();
        end

        // Asynchronous reset in the middle of SEED.
        seed = $urandom; seed_req = 1'b1; cyc(); seed_req = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 30; i++) cyc();
        seed_and_wait($urandom, "post_rst");
        run_words(6, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
